ps2_keypad: RTL and testbench

//  PS/2 keyboard receiver and GBA keypad mapper; drives the 10-bit key bus consumed by io_register.

---
 rtl/ps2_keypad_pkg.sv | 81 ++++++++
 rtl/ps2_keypad_if.sv | 27 ++
 rtl/ps2_keypad_rx_frame.sv | 109 ++++++++++
 rtl/ps2_keypad.sv | 108 ++++++++++
 tb/tb_ps2_keypad.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keypad_pkg.sv
// ps2_keypad_pkg
//   Shared definitions for the PS/2 keypad path: scancode constants, the
//   KEYINPUT bit map (also used by io_register), decoder state encoding and
//   the scancode -> key bit lookup.
package ps2_keypad_pkg;

  // Scancode prefixes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // Normal-table scancodes
  localparam logic [7:0] SC_A     = 8'h22;
  localparam logic [7:0] SC_B     = 8'h1A;
  localparam logic [7:0] SC_SEL   = 8'h66;
  localparam logic [7:0] SC_START = 8'h5A;
  localparam logic [7:0] SC_R     = 8'h1B;
  localparam logic [7:0] SC_L     = 8'h1C;

  // Extended-table scancodes (preceded by E0)
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // KEYINPUT bit indices (bit=1 released, bit=0 pressed)
  localparam logic [3:0] KEY_A     = 4'd0;
  localparam logic [3:0] KEY_B     = 4'd1;
  localparam logic [3:0] KEY_SEL   = 4'd2;
  localparam logic [3:0] KEY_START = 4'd3;
  localparam logic [3:0] KEY_RIGHT = 4'd4;
  localparam logic [3:0] KEY_LEFT  = 4'd5;
  localparam logic [3:0] KEY_UP    = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd7;
  localparam logic [3:0] KEY_R     = 4'd8;
  localparam logic [3:0] KEY_L     = 4'd9;

  localparam logic [9:0] KEYINPUT_RST = 10'h3FF;

  // Bit counter value of the stop bit (start=0 .. stop=10)
  localparam logic [3:0] FRAME_LAST = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Normal and extended tables are disjoint: a normal code after E0 misses.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t h;
    h.hit = 1'b1;
    h.idx = 4'd0;
    if (!ext) begin
      case (code)
        SC_A:     h.idx = KEY_A;
        SC_B:     h.idx = KEY_B;
        SC_SEL:   h.idx = KEY_SEL;
        SC_START: h.idx = KEY_START;
        SC_R:     h.idx = KEY_R;
        SC_L:     h.idx = KEY_L;
        default:  h.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_RIGHT: h.idx = KEY_RIGHT;
        SC_LEFT:  h.idx = KEY_LEFT;
        SC_UP:    h.idx = KEY_UP;
        SC_DOWN:  h.idx = KEY_DOWN;
        default:  h.hit = 1'b0;
      endcase
    end
    return h;
  endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// ps2_keypad_if
//   Bundles the PS/2 line inputs and the keypad outputs.
//   master: PS/2 device / system side (drives ps2_clk, ps2_data)
//   slave : ps2_keypad (drives keyinput, key_irq, frame_err)
interface ps2_keypad_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] keyinput;
  logic       key_irq;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keyinput,
    input  key_irq,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keyinput,
    output key_irq,
    output frame_err
  );
endinterface

// File: rtl/ps2_keypad_rx_frame.sv
// ps2_rx_frame
//   PS/2 frame receiver: 2-FF synchronisers, ps2_clk glitch filter, falling
//   edge strobe, 11-bit frame assembly, odd parity / stop check, idle timeout.
// Ports
//   clk, rstn     system clock, async active-low reset
//   i_ps2_clk     raw PS/2 clock (asynchronous)
//   i_ps2_data    raw PS/2 data (asynchronous)
//   o_byte_valid  1-cycle pulse, cycle after the stop-bit strobe, good frame
//   o_byte        received byte, valid with o_byte_valid
//   o_frame_err   1-cycle pulse, same timing, parity or stop error
module ps2_rx_frame
  import ps2_keypad_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic [3:0]    r_bitcnt;
  logic [8:0]    r_shift;
  logic [IW-1:0] r_idle;
  logic          w_accept;
  logic          w_strobe;

  // A new level is accepted on the FILTER_LEN-th consecutive differing sample.
  assign w_accept = (r_clk_s2 != r_clk_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_strobe = w_accept && r_clk_filt;

  // Synchronisers and glitch filter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_accept) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame control: bit counter, validity pulses, idle timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bitcnt     <= '0;
      r_idle       <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_strobe) begin
        r_idle <= '0;
        if (r_bitcnt == 4'd0) begin
          // A start bit sampled high is line noise; stay idle.
          if (!r_dat_s2) r_bitcnt <= 4'd1;
        end else if (r_bitcnt == FRAME_LAST) begin
          r_bitcnt <= '0;
          // r_shift holds data[7:0] and parity; odd overall parity required.
          if (r_dat_s2 && (^r_shift)) o_byte_valid <= 1'b1;
          else                        o_frame_err  <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end else if (r_bitcnt != 4'd0) begin
        if (r_idle == IW'(TIMEOUT_CYC - 1)) begin
          r_bitcnt <= '0;
          r_idle   <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  // Data path: LSB-first shift of data bits and parity; no reset needed.
  always_ff @(posedge clk) begin
    if (w_strobe && (r_bitcnt != 4'd0) && (r_bitcnt != FRAME_LAST))
      r_shift <= {r_dat_s2, r_shift[8:1]};
    if (w_strobe && (r_bitcnt == FRAME_LAST))
      o_byte <= r_shift[7:0];
  end

endmodule

// File: rtl/ps2_keypad.sv
// ps2_keypad
//   PS/2 keyboard receiver and GBA keypad mapper. Decodes make/break/E0
//   scancode sequences into the KEYINPUT-format key bus.
// Ports
//   clk            system clock
//   rstn           async active-low reset
//   bus (slave)    ps2_clk, ps2_data in; keyinput[9:0], key_irq, frame_err out
//     keyinput  bit=1 released, 0 pressed; [0]A [1]B [2]Sel [3]Start
//               [4]Right [5]Left [6]Up [7]Down [8]R [9]L
//     key_irq   1-cycle pulse when any keyinput bit goes 1->0
//     frame_err 1-cycle pulse on parity or stop-bit error
module ps2_keypad
  import ps2_keypad_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic         clk,
  input  logic         rstn,
  ps2_keypad_if.slave  bus
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_frame_err;

  dec_state_t r_state, w_state_nxt;
  logic [9:0] r_key, w_key_nxt;
  logic       r_irq, w_irq_nxt;
  logic       w_apply, w_make, w_ext;
  key_hit_t   w_hit;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk          (clk),
    .rstn         (rstn),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_key   <= KEYINPUT_RST;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_irq_nxt   = 1'b0;
    w_apply     = 1'b0;
    w_make      = 1'b0;
    w_ext       = 1'b0;
    if (w_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte == SC_EXT)      w_state_nxt = ST_EXT;
          else if (w_byte == SC_BRK) w_state_nxt = ST_BRK;
          else begin
            w_apply = 1'b1;
            w_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (w_byte == SC_BRK) w_state_nxt = ST_EXTBRK;
          else begin
            w_apply     = 1'b1;
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXTBRK: begin
          w_apply     = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_hit = key_lookup(w_byte, w_ext);
    if (w_apply && w_hit.hit) begin
      // A typematic repeat finds the bit already 0, so no irq is raised.
      w_key_nxt[w_hit.idx] = ~w_make;
      w_irq_nxt            = w_make && r_key[w_hit.idx];
    end
  end

  assign bus.keyinput  = r_key;
  assign bus.key_irq   = r_irq;
  assign bus.frame_err = w_frame_err;

endmodule

// File: tb/tb_ps2_keypad.sv
module tb_ps2_keypad;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 20;   // half PS/2 bit period in clk cycles

  logic clk;
  logic rstn;
  ps2_keypad_if ifc();

  ps2_keypad #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Activity monitor
  int         cyc = 0;
  int         irq_cnt = 0;
  int         ferr_cnt = 0;
  int         irq_cyc = -1;
  int         chg_cyc = -2;
  logic [9:0] prev_key = 10'h3FF;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.key_irq === 1'b1) begin
      irq_cnt = irq_cnt + 1;
      irq_cyc = cyc;
    end
    if (ifc.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (ifc.keyinput !== prev_key) chg_cyc = cyc;
    prev_key = ifc.keyinput;
  end

  // Reference model of the keypad
  logic [9:0] m_key;
  bit         m_ext, m_brk;
  int         m_irq;

  function automatic int key_index(input logic [7:0] code, input bit ext);
    if (!ext) begin
      case (code)
        8'h22: return 0;
        8'h1A: return 1;
        8'h66: return 2;
        8'h5A: return 3;
        8'h1B: return 8;
        8'h1C: return 9;
        default: return -1;
      endcase
    end
    case (code)
      8'h74: return 4;
      8'h6B: return 5;
      8'h75: return 6;
      8'h72: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_key = 10'h3FF;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    if (m_brk) begin
      idx = key_index(b, m_ext);
      if (idx >= 0) m_key[idx] = 1'b1;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && b == 8'hE0) begin
      m_ext = 1;
    end else begin
      idx = key_index(b, m_ext);
      if (idx >= 0) begin
        if (m_key[idx] == 1'b1) m_irq++;
        m_key[idx] = 1'b0;
      end
      m_ext = 0;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first nbits of a frame; ends with ps2_clk high.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ifc.ps2_data = f[i];
      wait_clk(HALF);
      ifc.ps2_clk = 1'b0;
      wait_clk(HALF);
      ifc.ps2_clk = 1'b1;
    end
    wait_clk(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 0, 0, 11);
    model_byte(b);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    model_reset();
    wait_clk(5);
    checks++;
    if (ifc.keyinput !== 10'h3FF) begin errs++; $display("FAIL reset_key got=%h exp=3ff", ifc.keyinput); end
    checks++;
    if (ifc.key_irq !== 1'b0 || ifc.frame_err !== 1'b0) begin
      errs++; $display("FAIL reset_pulses irq=%b ferr=%b exp=0/0", ifc.key_irq, ifc.frame_err);
    end
    rstn = 1'b1;
    wait_clk(TIMEOUT_CYC);
    checks++;
    if (ifc.keyinput !== 10'h3FF || irq_cnt != 0 || ferr_cnt != 0) begin
      errs++; $display("FAIL reset_idle key=%h irq=%0d ferr=%0d exp=3ff/0/0", ifc.keyinput, irq_cnt, ferr_cnt);
    end
  endtask

  task automatic test_make_break();
    int irq0;
    irq0 = irq_cnt;
    send_byte(8'h22);
    checks++;
    if (ifc.keyinput !== 10'h3FE) begin errs++; $display("FAIL make_a got=%h exp=3fe", ifc.keyinput); end
    checks++;
    if (irq_cnt != irq0 + 1) begin errs++; $display("FAIL make_a_irq count=%0d exp=%0d", irq_cnt, irq0 + 1); end
    checks++;
    if (irq_cyc != chg_cyc) begin errs++; $display("FAIL irq_align irq_cyc=%0d key_change_cyc=%0d", irq_cyc, chg_cyc); end
    send_byte(8'hF0);
    send_byte(8'h22);
    checks++;
    if (ifc.keyinput !== 10'h3FF || irq_cnt != irq0 + 1) begin
      errs++; $display("FAIL break_a key=%h irq=%0d exp=3ff/%0d", ifc.keyinput, irq_cnt, irq0 + 1);
    end
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    checks++;
    if (ifc.keyinput !== 10'h3BF) begin errs++; $display("FAIL ext_up_make got=%h exp=3bf", ifc.keyinput); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++;
    if (ifc.keyinput !== 10'h3FF) begin errs++; $display("FAIL ext_up_break got=%h exp=3ff", ifc.keyinput); end
    send_byte(8'h75);
    checks++;
    if (ifc.keyinput !== 10'h3FF) begin errs++; $display("FAIL bare_75 got=%h exp=3ff", ifc.keyinput); end
    send_byte(8'hE0); send_byte(8'h22);
    checks++;
    if (ifc.keyinput !== 10'h3FF) begin errs++; $display("FAIL e0_normal got=%h exp=3ff", ifc.keyinput); end
  endtask

  task automatic test_glitch();
    // Short low pulse on ps2_clk with data low must not start a frame.
    ifc.ps2_data = 1'b0;
    wait_clk(2);
    ifc.ps2_clk = 1'b0;
    wait_clk(3);
    ifc.ps2_clk = 1'b1;
    wait_clk(2);
    ifc.ps2_data = 1'b1;
    send_byte(8'h5A);
    checks++;
    if (ifc.keyinput !== 10'h3F7) begin errs++; $display("FAIL glitch got=%h exp=3f7", ifc.keyinput); end
    send_byte(8'hF0); send_byte(8'h5A);
  endtask

  task automatic test_frame_err();
    int f0, irq0;
    f0 = ferr_cnt;
    irq0 = irq_cnt;
    send_bits(8'h22, 1, 0, 11);
    checks++;
    if (ferr_cnt != f0 + 1 || ifc.keyinput !== 10'h3FF) begin
      errs++; $display("FAIL parity_err ferr=%0d key=%h exp=%0d/3ff", ferr_cnt, ifc.keyinput, f0 + 1);
    end
    send_byte(8'h1A);
    checks++;
    if (ifc.keyinput !== 10'h3FD || ferr_cnt != f0 + 1) begin
      errs++; $display("FAIL after_parity key=%h ferr=%0d exp=3fd/%0d", ifc.keyinput, ferr_cnt, f0 + 1);
    end
    send_bits(8'h66, 0, 1, 11);
    checks++;
    if (ferr_cnt != f0 + 2 || ifc.keyinput !== 10'h3FD || irq_cnt != irq0 + 1) begin
      errs++; $display("FAIL stop_err ferr=%0d key=%h irq=%0d exp=%0d/3fd/%0d", ferr_cnt, ifc.keyinput, irq_cnt, f0 + 2, irq0 + 1);
    end
    send_byte(8'hF0); send_byte(8'h1A);
  endtask

  task automatic test_timeout();
    int irq0;
    irq0 = irq_cnt;
    send_bits(8'h5A, 0, 0, 5);
    wait_clk(TIMEOUT_CYC + TIMEOUT_CYC / 20);
    send_byte(8'h1C);
    checks++;
    if (ifc.keyinput !== 10'h1FF) begin errs++; $display("FAIL timeout_l got=%h exp=1ff", ifc.keyinput); end
    for (int i = 0; i < 3; i++) send_byte(8'h1C);
    checks++;
    if (ifc.keyinput !== 10'h1FF || irq_cnt != irq0 + 1) begin
      errs++; $display("FAIL typematic key=%h irq=%0d exp=1ff/%0d", ifc.keyinput, irq_cnt, irq0 + 1);
    end
    send_byte(8'hF0); send_byte(8'h1C);
  endtask

  task automatic test_back_to_back();
    // Right and Left together, then A, with no gap between frames.
    send_byte(8'hE0); send_byte(8'h74);
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'h22);
    checks++;
    if (ifc.keyinput !== m_key || m_key !== 10'h3CE) begin
      errs++; $display("FAIL back_to_back got=%h exp=3ce", ifc.keyinput);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [16];
    logic [7:0] b;
    pool = '{8'h22, 8'h1A, 8'h66, 8'h5A, 8'h1B, 8'h1C, 8'h74, 8'h6B,
             8'h75, 8'h72, 8'hE0, 8'hF0, 8'hF0, 8'h12, 8'hAA, 8'hE1};
    for (int i = 0; i < 30; i++) begin
      b = pool[$urandom_range(15, 0)];
      send_byte(b);
      checks++;
      if (ifc.keyinput !== m_key || irq_cnt != m_irq) begin
        errs++;
        $display("FAIL random[%0d] byte=%h key=%h irq=%0d exp=%h/%0d", i, b, ifc.keyinput, irq_cnt, m_key, m_irq);
      end
      wait_clk($urandom_range(30, 0));
    end
  endtask

  task automatic test_reset_midframe();
    int f0, irq0;
    send_bits(8'h5A, 0, 0, 6);
    ifc.ps2_data = 1'b0;
    wait_clk(HALF);
    ifc.ps2_clk = 1'b0;
    wait_clk(3);
    rstn = 1'b0;
    model_reset();
    wait_clk(3);
    checks++;
    if (ifc.keyinput !== 10'h3FF || ifc.key_irq !== 1'b0 || ifc.frame_err !== 1'b0) begin
      errs++; $display("FAIL midreset_outputs key=%h irq=%b ferr=%b exp=3ff/0/0", ifc.keyinput, ifc.key_irq, ifc.frame_err);
    end
    ifc.ps2_clk  = 1'b1;
    ifc.ps2_data = 1'b1;
    wait_clk(5);
    rstn = 1'b1;
    f0 = ferr_cnt;
    irq0 = irq_cnt;
    wait_clk(5);
    send_byte(8'h66);
    checks++;
    if (ifc.keyinput !== 10'h3FB || ferr_cnt != f0 || irq_cnt != irq0 + 1) begin
      errs++; $display("FAIL midreset_66 key=%h ferr=%0d irq=%0d exp=3fb/%0d/%0d", ifc.keyinput, ferr_cnt, irq_cnt, f0, irq0 + 1);
    end
  endtask

  initial begin
    m_irq = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_glitch();
    test_frame_err();
    test_timeout();
    test_back_to_back();
    test_random();
    m_irq = irq_cnt;
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
